fp16_add_seq: RTL and testbench
===============================

# fp16_add_seq

Multi-cycle sequencer for half-precision (1/5/10) floating-point addition. Accepts one operand pair through a valid/ready handshake and steps it through four stages: align, add, normalize, pack. The normalize stage uses an 11-bit leading-one vector and an 11-to-5 one-hot encoder to get the left-shift amount. The block sits between the FP operand issue logic and the result writeback, and only one operation is in flight at a time.

## Interface
- No parameters; all widths are fixed to IEEE-754 binary16.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept; high only in IDLE
- a  in  16  operand A (sign[15], exp[14:10], frac[9:0])
- b  in  16  operand B, same format
- out_valid  out  1  result present; held until taken
- out_ready  in  1  consumer takes result
- sum  out  16  result, stable while out_valid
- ovf  out  1  result overflowed to infinity; qualified by out_valid

## Operation
- States are IDLE, ALIGN, ADD, NORM, DONE.
- IDLE
  - in_ready=1.
  - When in_valid&&in_ready: capture a and b, go to ALIGN.
- ALIGN
  - Operand classification:
    - exp==0 → operand treated as +/-0; denormals are flushed.
    - exp==31 → operand is special.
  - Significand is {1,frac} (11 bits), or 0 for a zero operand.
  - Order operands by magnitude ({exp,frac} compare). The larger one sets the result sign and the base exponent.
  - Shift the smaller significand right by the exponent difference, truncating shifted-out bits.
  - A difference ≥11 gives 0.
- ADD
  - Equal signs: 12-bit add.
  - Opposite signs: larger minus smaller; the result is never negative.
- NORM
  - If bit11 is set: shift right 1, exp+1.
  - Else if the result is nonzero:
    - Form a one-hot leading-one vector over bits[10:0].
    - Encode it to a 5-bit position p (0..10).
    - Shift left by 10-p and subtract 10-p from exp.
  - Result zero → sum=0x0000 (+0), including exact cancellation.
  - exp ≥31 after adjust → sum={sign,5'h1F,10'h0}, ovf=1.
  - exp ≤0 after adjust → flush to signed zero.
- Specials take priority and bypass ADD/NORM arithmetic, but still traverse the states so latency stays fixed:
  - Any NaN input (exp=31, frac≠0) → 0x7E00.
  - Inf + inf of opposite sign → 0x7E00.
  - Inf otherwise → that inf, ovf=0.
- DONE
  - out_valid=1.
  - When out_ready: go to IDLE. in_ready rises the following cycle.
- Rounding is truncation (round toward zero on the magnitude). There are no guard or sticky bits.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=16'h0000, ovf=0, all internal registers 0.
- Reset asserted mid-operation aborts the operation immediately. No output is produced, and in_ready is high the first cycle after deassertion.
- Latency: accept in cycle N; out_valid=1 from cycle N+4.
- Throughput is at most one result per 5 cycles (accept, 3 working cycles, DONE with immediate out_ready).
- in_ready=0 in all states except IDLE. in_valid while busy is ignored, not queued.
- in_valid and out_ready are never acted on in the same cycle, because DONE and IDLE are distinct states.
- While out_valid=1 and out_ready=0, sum and ovf are held constant for any number of cycles.
- a and b may change freely after the accept cycle; internal copies are used.

## Test plan
- 1.0 + 1.0: a=0x3C00, b=0x3C00 → sum=0x4000, ovf=0, out_valid exactly 4 cycles after accept.
- Subtraction needing a left shift of 2: a=0x3C00, b=0xBA00 (-0.75) → sum=0x3400 (0.25); encoder position p=8.
- Cancellation: a=0x3C00, b=0xBC00 → sum=0x0000. Also a=0x3E00 (1.5), b=0x3800 (0.5) → sum=0x4000 (carry path).
- Overflow: a=0x7BFF, b=0x7BFF → sum=0x7C00, ovf=1. Specials: a=0x7C00, b=0xFC00 → sum=0x7E00.
- Backpressure and busy: hold out_ready=0 for 10 cycles → sum stable, out_valid stays 1. in_valid pulsed with a new pair while busy → ignored; the next accept occurs only after DONE→IDLE.
- Reset mid-op: assert rst in the ALIGN cycle → out_valid stays 0, in_ready=1 after release. The next op (0x3C00 + 0x3C00) returns 0x4000.

Source files
------------

// File: rtl/fp16_add_seq_if.sv
// fp16_add_seq_if: operand/result handshake bundle for the fp16 adder sequencer
interface fp16_add_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        ovf;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, ovf);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, ovf);
endinterface

// File: rtl/fp16_add_seq.sv
// fp16_add_seq: four-step (align/add/normalize/pack) binary16 adder, one op in flight, truncating
module fp16_add_seq (
    input logic           clk,
    input logic           rst,
    fp16_add_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
    logic [4:0]  exp_q, exp_d;
    logic [10:0] big_q, big_d, small_q, small_d;
    logic [15:0] spec_val_q, spec_val_d;
    logic [11:0] res_q, res_d;
    logic [15:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        a_gt, a_nan, b_nan, a_inf, b_inf;
    logic [15:0] x, y;
    logic [4:0]  diff;
    logic [10:0] sig_x, sig_y;
    logic [10:0] lead;
    logic [4:0]  pos, shift;
    logic signed [6:0] e_n;
    logic [9:0]  frac_n;
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;
    assign a_gt  = a_q[14:0] >= b_q[14:0];
    assign x     = a_gt ? a_q : b_q;
    assign y     = a_gt ? b_q : a_q;
    assign sig_x = x[14:10] == 5'd0 ? 11'd0 : {1'b1, x[9:0]};
    assign sig_y = y[14:10] == 5'd0 ? 11'd0 : {1'b1, y[9:0]};
    assign diff  = x[14:10] - y[14:10];
    assign a_nan = &a_q[14:10] && |a_q[9:0];
    assign b_nan = &b_q[14:10] && |b_q[9:0];
    assign a_inf = &a_q[14:10] && ~|a_q[9:0];
    assign b_inf = &b_q[14:10] && ~|b_q[9:0];
    // Leading-one one-hot over the sum, then encoded to its bit position
    always_comb begin
        lead = '0;
        pos  = '0;
        for (int i = 0; i < 11; i++) lead[i] = res_q[i] & ~|(res_q[10:0] >> (i + 1));
        for (int i = 0; i < 11; i++) pos = pos | (lead[i] ? 5'(i) : 5'd0);
        shift  = 5'd10 - pos;
        e_n    = res_q[11] ? $signed({2'b0, exp_q}) + 7'sd1 : $signed({2'b0, exp_q}) - $signed({2'b0, shift});
        frac_n = res_q[11] ? res_q[10:1] : 10'(res_q << shift);
    end
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        spec_d     = spec_q;
        exp_d      = exp_q;
        big_d      = big_q;
        small_d    = small_q;
        spec_val_d = spec_val_q;
        res_d      = res_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = bus.b;
                state_d = ALIGN;
            end
            ALIGN: begin
                sign_d     = x[15];
                sub_d      = x[15] ^ y[15];
                exp_d      = x[14:10];
                big_d      = sig_x;
                small_d    = sig_y >> diff;
                spec_d     = &a_q[14:10] || &b_q[14:10];
                spec_val_d = (a_nan || b_nan || (a_inf && b_inf && (a_q[15] ^ b_q[15]))) ? 16'h7E00 : a_inf ? a_q : b_q;
                state_d    = ADD;
            end
            ADD: begin
                res_d   = sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};
                state_d = NORM;
            end
            NORM: begin
                sum_d   = spec_q ? spec_val_q :
                          res_q == 12'd0 ? 16'h0000 :
                          e_n >= 7'sd31 ? {sign_q, 5'h1F, 10'h0} :
                          e_n <= 7'sd0 ? {sign_q, 15'h0} : {sign_q, e_n[4:0], frac_n};
                ovf_d   = !spec_q && res_q != 12'd0 && e_n >= 7'sd31;
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            spec_q     <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            spec_val_q <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            spec_q     <= spec_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            spec_val_q <= spec_val_d;
            res_q      <= res_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fp16_add_seq.sv
// tb_fp16_add_seq: directed vectors with hand-computed binary16 sums
module tb_fp16_add_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    fp16_add_seq_if bus ();
    fp16_add_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp_s, input logic exp_o, input int hold);
        int   lat;
        logic stable;
        @(negedge clk);
        check({tag, " in_ready"}, {15'd0, bus.in_ready}, 16'd1);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 16'(lat), 16'd4);
        check({tag, " sum"}, bus.sum, exp_s);
        check({tag, " ovf"}, {15'd0, bus.ovf}, {15'd0, exp_o});
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (bus.sum !== exp_s || bus.out_valid !== 1'b1 || bus.ovf !== exp_o) stable = 1'b0;
        end
        if (hold > 0) check({tag, " held"}, {15'd0, stable}, 16'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, {15'd0, bus.out_valid}, 16'd0);
        check({tag, " in_ready back"}, {15'd0, bus.in_ready}, 16'd1);
    endtask
    initial begin
        int   lat;
        logic busy_ok;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", {15'd0, bus.in_ready}, 16'd1);
        check("reset out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("reset sum", bus.sum, 16'h0000);
        check("reset ovf", {15'd0, bus.ovf}, 16'd0);
        rst = 1'b0;
        run_op("1+1", 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 0);
        run_op("1-0.75", 16'h3C00, 16'hBA00, 16'h3400, 1'b0, 0);
        run_op("cancel", 16'h3C00, 16'hBC00, 16'h0000, 1'b0, 0);
        run_op("1.5+0.5", 16'h3E00, 16'h3800, 16'h4000, 1'b0, 0);
        run_op("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 0);
        run_op("inf-inf", 16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 0);
        run_op("nan", 16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 0);
        run_op("inf+1", 16'h3C00, 16'h7C00, 16'h7C00, 1'b0, 0);
        run_op("-inf-inf", 16'hFC00, 16'hFC00, 16'hFC00, 1'b0, 0);
        run_op("-2+1", 16'hC000, 16'h3C00, 16'hBC00, 1'b0, 0);
        run_op("1+0", 16'h0000, 16'h3C00, 16'h3C00, 1'b0, 0);
        run_op("denorm", 16'h0001, 16'h0000, 16'h0000, 1'b0, 0);
        run_op("underflow", 16'h8600, 16'h0400, 16'h8000, 1'b0, 0);
        run_op("far", 16'h3C00, 16'h0C00, 16'h3C00, 1'b0, 0);
        run_op("trunc", 16'h3C00, 16'h3401, 16'h3D00, 1'b0, 0);
        run_op("backpressure", 16'h3C00, 16'hBA00, 16'h3400, 1'b0, 10);
        // A pair offered while busy must be dropped, not queued
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h3C00;
        bus.b = 16'h3C00;
        @(negedge clk);
        bus.a = 16'h7BFF;
        bus.b = 16'h7BFF;
        busy_ok = 1'b1;
        repeat (3) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("busy in_ready low", {15'd0, busy_ok}, 16'd1);
        check("busy out_valid", {15'd0, bus.out_valid}, 16'd1);
        check("busy sum", bus.sum, 16'h4000);
        check("busy ovf", {15'd0, bus.ovf}, 16'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("busy not queued", {15'd0, bus.out_valid}, 16'd0);
        // Reset during ALIGN aborts the op
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h7BFF;
        bus.b = 16'h7BFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst in_ready", {15'd0, bus.in_ready}, 16'd1);
        busy_ok = 1'b1;
        repeat (6) begin
            if (bus.out_valid !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
        end
        check("rst no output", {15'd0, busy_ok}, 16'd1);
        run_op("post-rst 1+1", 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
